mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arb_steer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, owner encodings and counter width for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int CNT_W = 8;
endpackage

// File: rtl/mem_arb_steer.sv
// mem_arb_steer: steers the owner's address/wdata/we onto the memory port and gates rdata back
module mem_arb_steer
  import mem_arb_pkg::*;
(
  input  logic        busy,
  input  logic        sel_d,
  input  logic        i_rvalid,
  input  logic        d_rvalid,
  input  logic        d_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata
);
  logic own_d;
  assign own_d = busy & (sel_d == OWN_D);
  assign mem_we = own_d & d_we;
  assign mem_addr = !busy ? '0 : own_d ? d_addr : i_addr;
  assign mem_wdata = own_d ? d_wdata : '0;
  assign i_rdata = i_rvalid ? mem_rdata : '0;
  assign d_rdata = d_rvalid ? mem_rdata : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for one memory port with access timeout.
// MEM_ARB_FAIR_EN selects round-robin tie-break in IDLE; otherwise data always wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        sel_d
);
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic busy, done, tmo, pick_d, other, same, go, nxt_d;
  assign busy = st != IDLE;
  assign done = reset_n & busy & mem_ready;
  assign tmo = reset_n & busy & !mem_ready & (cnt == CNT_W'(TIMEOUT - 1));
`ifdef MEM_ARB_FAIR_EN
  logic last;
  assign pick_d = d_req & (!i_req | (last == OWN_I));
  always_ff @(posedge clk)
    if (!reset_n) last <= OWN_I;
    else if (go) last <= nxt_d;
`else
  assign pick_d = d_req;
`endif
  // on completion the other requester is served first, so back-to-back traffic never bubbles
  assign other = sel_d ? i_req : d_req;
  assign same = sel_d ? d_req : i_req;
  assign go = reset_n & (busy ? done & (other | same) : (i_req | d_req));
  assign nxt_d = busy ? (other ? !sel_d : sel_d) : pick_d;
  assign i_gnt = go & !nxt_d;
  assign d_gnt = go & nxt_d;
  assign i_rvalid = done & (sel_d == OWN_I);
  assign d_rvalid = done & (sel_d == OWN_D);
  assign i_err = tmo & (sel_d == OWN_I);
  assign d_err = tmo & (sel_d == OWN_D);
  assign mem_req = busy;
  always_ff @(posedge clk)
    if (!reset_n) begin
      st <= IDLE;
      sel_d <= OWN_I;
      cnt <= '0;
    end else if (go) begin
      st <= nxt_d ? BUSY_D : BUSY_I;
      sel_d <= nxt_d;
      cnt <= '0;
    end else if (done | tmo) begin
      st <= IDLE;
      cnt <= '0;
    end else if (busy) cnt <= cnt + 1'b1;
  mem_arb_steer u_steer (
    .busy(busy),
    .sel_d(sel_d),
    .i_rvalid(i_rvalid),
    .d_rvalid(d_rvalid),
    .d_we(d_we),
    .i_addr(i_addr),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .i_rdata(i_rdata),
    .d_rdata(d_rdata)
  );
endmodule
